xadc_channel_scanner: RTL and testbench
=======================================

# xadc_channel_scanner

Parametrised multi-channel acquisition engine for the voltmeter datapath. It sequences XADC DRP reads over CH_NUM consecutive channel addresses and averages 2^AVG_LOG2 samples per channel. Each average is scaled to millivolts and stored in a result bank that the seven-segment, UART and VGA consumers read by index. It supersedes the single-channel `dout` path and sits between the XADC primitive wrapper and the display/UART controllers on the 100 MHz domain.

## Interface
- CH_NUM, 13: number of scanned channels (1..16).
- FIRST_ADDR, 7'h10: DRP address of channel 0; channel i uses FIRST_ADDR+i.
- AVG_LOG2, 2: log2 of samples averaged per channel (0..4).
- FULL_SCALE_MV, 1000: millivolts corresponding to ADC code 4096.
- TIMEOUT, 64: cycles to wait for drdy before abandoning a channel.
- CONTINUOUS, 0: 1 means a new frame starts automatically after each completed frame.
- CH_W, $clog2(CH_NUM): channel index width (derived, not overridden).

Ports:
- clk  in  1  system clock (clk100Mhz domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request pulse; honoured only in IDLE.
- drp_den  out  1  DRP enable, one-cycle pulse per read.
- drp_daddr  out  7  DRP address, valid while drp_den=1.
- drp_drdy  in  1  DRP read data valid.
- drp_do  in  16  DRP data; ADC code is drp_do[15:4].
- busy  out  1  high from frame start until return to IDLE.
- frame_done  out  1  one-cycle pulse after the last channel is stored.
- err  out  CH_NUM  per-channel timeout flags; cleared at each frame start.
- rd_ch  in  CH_W  result bank read index.
- rd_mv  out  16  millivolt value of channel rd_ch, registered.

## Operation
- States: IDLE, REQ, WAIT, SCALE, STORE, NEXT, DONE.
- IDLE: start=1 (or CONTINUOUS=1 after DONE) clears err, ch=0, smp=0, acc=0, and goes to REQ.
- REQ: drp_den=1 and drp_daddr=FIRST_ADDR+ch for exactly one cycle; wait counter cleared; go to WAIT.
- WAIT: on drp_drdy=1, acc += drp_do[15:4] and smp++. If smp was 2^AVG_LOG2-1, go to SCALE; otherwise go to REQ. If the wait counter reaches TIMEOUT with no drdy, set err[ch], leave the bank entry unchanged and go to NEXT.
- SCALE: avg = acc >> AVG_LOG2 (12 bits); prod = avg * FULL_SCALE_MV, registered at full width; mv = prod >> 12, truncated and held in 16 bits.
- STORE: bank[ch] <= mv.
- NEXT: if ch==CH_NUM-1, go to DONE; otherwise ch++, smp=0, acc=0, go to REQ.
- DONE: frame_done=1 for one cycle. Go to IDLE; with CONTINUOUS=1, go directly to the frame-start actions instead.
- acc width is 12+AVG_LOG2 and never overflows.
- drp_drdy outside WAIT is ignored. start outside IDLE is ignored.
- Read port: rd_mv <= (rd_ch < CH_NUM) ? bank[rd_ch] : 0 every cycle. It is read-before-write: a read of the channel being stored returns the old value, and the new value appears one cycle later.
- Reset, including mid-frame: state=IDLE, drp_den=0, drp_daddr=0, busy=0, frame_done=0, err=0, rd_mv=0, all bank entries=0. An in-flight drdy after reset is ignored.

## Timing
- start sampled high in cycle 0 leads to the first REQ in cycle 1, with busy=1 from cycle 1.
- DRP latency L means drdy arrives L cycles after REQ. The next REQ follows one cycle after drdy, so each sample costs L+1 cycles.
- Per channel: 2^AVG_LOG2*(L+1) + 3 cycles (SCALE, STORE, NEXT).
- Per timed-out channel: 1 + TIMEOUT + 1 cycles.
- frame_done pulses in the cycle after the last NEXT. busy falls in the following cycle, or stays high with CONTINUOUS=1.
- rd_mv latency: 1 cycle from rd_ch.

## Test plan
- Single frame, defaults, L=4, every channel returning code 12'h800: frame_done at cycle 1+13*23=300; every bank entry reads 500; err=0.
- Averaging, AVG_LOG2=2: channel 3 returns codes 100, 200, 300, 400, giving avg 250 and rd_mv=(250*1000)>>12=61; other channels are unaffected.
- Timeout: drdy withheld for channel 5 only. err=13'h0020, bank[5] keeps its previous frame value, and frame_done arrives late by exactly the computed timeout cost.
- CONTINUOUS=1: no start after the first frame; a second REQ to FIRST_ADDR follows the frame_done cycle directly, and busy never deasserts.
- Reset at cycle 50 of a frame: in the next cycle drp_den=0, busy=0, rd_mv=0 and the bank is cleared. A drdy driven at cycle 52 does not alter state; a new start runs a clean frame.
- Boundary checks: start pulsed while busy is ignored. rd_ch=14 with CH_NUM=13 returns rd_mv=0. Code 12'hFFF gives 999 mV.

Source files
------------

// File: rtl/xadc_channel_scanner.sv
// rtl/xadc_channel_scanner.sv - multi-channel XADC DRP scanner with averaging and millivolt result bank
//
// Walks CH_NUM consecutive DRP addresses starting at FIRST_ADDR, averages
// 2^AVG_LOG2 ADC codes per channel, scales the average to millivolts and
// stores it in a per-channel result bank read through a registered port.
//
// Ports:
//   clk         system clock (100 MHz domain)
//   rst         synchronous active-high reset
//   start       frame request pulse, honoured only while idle
//   drp_den     DRP enable, one-cycle pulse per read
//   drp_daddr   DRP address, valid while drp_den is high
//   drp_drdy    DRP read data valid
//   drp_do      DRP read data, ADC code in bits [15:4]
//   busy        high from frame start until the scanner is idle again
//   frame_done  one-cycle pulse after the last channel is handled
//   err         per-channel timeout flags, cleared at each frame start
//   rd_ch       result bank read index
//   rd_mv       millivolt value of channel rd_ch, one cycle latency

module xadc_channel_scanner #(
    parameter int         CH_NUM        = 13,
    parameter logic [6:0] FIRST_ADDR    = 7'h10,
    parameter int         AVG_LOG2      = 2,
    parameter int         FULL_SCALE_MV = 1000,
    parameter int         TIMEOUT       = 64,
    parameter int         CONTINUOUS    = 0,
    parameter int         CH_W          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              drp_den,
    output logic [6:0]        drp_daddr,
    input  logic              drp_drdy,
    input  logic [15:0]       drp_do,
    output logic              busy,
    output logic              frame_done,
    output logic [CH_NUM-1:0] err,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [15:0]       rd_mv
);

    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int PROD_W = 12 + $clog2(FULL_SCALE_MV + 1);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [4:0]        SMP_LAST = 5'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CH_NUM - 1);
    localparam logic [WCNT_W-1:0] WCNT_END = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SCALE,
        S_STORE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [4:0]          smp;
    logic [ACC_W-1:0]    acc;
    logic [WCNT_W-1:0]   wcnt;
    logic [PROD_W-1:0]   prod;
    logic [15:0]         bank [CH_NUM];

    logic                frame_go;
    logic [11:0]         avg;
    logic [15:0]         mv;
    logic                unused_low_bits;

    // The low nibble of drp_do carries no ADC information.
    assign unused_low_bits = ^drp_do[3:0];

    // A frame begins either on a start request while idle or, in continuous
    // mode, straight out of DONE so the next REQ follows frame_done directly.
    assign frame_go = ((state == S_IDLE) && start) ||
                      ((state == S_DONE) && (CONTINUOUS != 0));

    assign avg = 12'(acc >> AVG_LOG2);

    // Zero-extend before shifting so narrow products never lose the integer part.
    assign mv = 16'({16'd0, prod} >> 12);

    function automatic logic [6:0] addr_of(input logic [CH_W-1:0] c);
        return FIRST_ADDR + 7'(c);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ch         <= '0;
            smp        <= '0;
            acc        <= '0;
            wcnt       <= '0;
            prod       <= '0;
            drp_den    <= 1'b0;
            drp_daddr  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                bank[i] <= '0;
            end
        end else begin
            drp_den    <= 1'b0;
            frame_done <= 1'b0;
            if (frame_go) begin
                state     <= S_REQ;
                busy      <= 1'b1;
                err       <= '0;
                ch        <= '0;
                smp       <= '0;
                acc       <= '0;
                drp_den   <= 1'b1;
                drp_daddr <= addr_of('0);
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_REQ: begin
                        // drp_den was raised on entry, so it is high for this cycle only.
                        wcnt  <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (drp_drdy) begin
                            acc <= acc + ACC_W'(drp_do[15:4]);
                            smp <= smp + 5'd1;
                            if (smp == SMP_LAST) begin
                                state <= S_SCALE;
                            end else begin
                                state     <= S_REQ;
                                drp_den   <= 1'b1;
                                drp_daddr <= addr_of(ch);
                            end
                        end else if (wcnt == WCNT_END) begin
                            // Abandon the channel; its bank entry keeps the old value.
                            err[ch] <= 1'b1;
                            state   <= S_NEXT;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    S_SCALE: begin
                        prod  <= PROD_W'(avg) * PROD_W'(FULL_SCALE_MV);
                        state <= S_STORE;
                    end
                    S_STORE: begin
                        bank[ch] <= mv;
                        state    <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (ch == CH_LAST) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            ch        <= ch + 1'b1;
                            smp       <= '0;
                            acc       <= '0;
                            state     <= S_REQ;
                            drp_den   <= 1'b1;
                            drp_daddr <= addr_of(ch + 1'b1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Read-before-write: a store to rd_ch in the same cycle shows up one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_mv <= '0;
        end else if (int'(rd_ch) < CH_NUM) begin
            rd_mv <= bank[rd_ch];
        end else begin
            rd_mv <= '0;
        end
    end

endmodule

// File: tb/tb_xadc_channel_scanner.sv
// tb/tb_xadc_channel_scanner.sv - directed scoreboard bench for xadc_channel_scanner

module tb_xadc_channel_scanner;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic        busy;
    logic        frame_done;
    logic [12:0] err;
    logic [3:0]  rd_ch;
    logic [15:0] rd_mv;

    logic        start_c;
    logic        drp_den_c;
    logic [6:0]  drp_daddr_c;
    logic        drp_drdy_c;
    logic [15:0] drp_do_c;
    logic        busy_c;
    logic        frame_done_c;
    logic [1:0]  err_c;
    logic [0:0]  rd_ch_c;
    logic [15:0] rd_mv_c;

    xadc_channel_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .drp_den    (drp_den),
        .drp_daddr  (drp_daddr),
        .drp_drdy   (drp_drdy),
        .drp_do     (drp_do),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .rd_ch      (rd_ch),
        .rd_mv      (rd_mv)
    );

    xadc_channel_scanner #(
        .CH_NUM     (2),
        .AVG_LOG2   (0),
        .TIMEOUT    (8),
        .CONTINUOUS (1)
    ) dut_c (
        .clk        (clk),
        .rst        (rst),
        .start      (start_c),
        .drp_den    (drp_den_c),
        .drp_daddr  (drp_daddr_c),
        .drp_drdy   (drp_drdy_c),
        .drp_do     (drp_do_c),
        .busy       (busy_c),
        .frame_done (frame_done_c),
        .err        (err_c),
        .rd_ch      (rd_ch_c),
        .rd_mv      (rd_mv_c)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   codes [16][4];
    bit   withhold [16];
    int   prev_mv [16];
    int   exp_q [$];
    logic force_drdy = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // DRP responders: fixed latency LAT for the main scanner, 1 for the continuous one.
    initial begin
        int cnt   = 0;
        int rch   = -1;
        int ridx  = 0;
        int nch;
        logic pend_c = 1'b0;
        drp_drdy   = 1'b0;
        drp_do     = '0;
        drp_drdy_c = 1'b0;
        drp_do_c   = '0;
        forever begin
            @(negedge clk);
            drp_drdy = 1'b0;
            drp_do   = '0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = 16'(codes[rch][ridx & 3] << 4);
                    ridx++;
                end
            end
            if (force_drdy) begin
                drp_drdy = 1'b1;
                drp_do   = 16'hABC0;
            end
            if (drp_den === 1'b1) begin
                nch = int'(drp_daddr) - 16;
                if (nch != rch) ridx = 0;
                rch = nch;
                if (!withhold[nch & 15]) cnt = LAT;
            end
            drp_drdy_c = pend_c;
            drp_do_c   = 16'h8000;
            pend_c     = (drp_den_c === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic read_mv(input int ch, output int v);
        @(negedge clk);
        rd_ch = 4'(ch);
        @(negedge clk);
        v = int'(rd_mv);
    endtask

    task automatic wait_done(input int exp_cyc, input string tag);
        int got = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                got = cyc;
                break;
            end
        end
        check(tag, got, exp_cyc);
    endtask

    function automatic int model_mv(input int ch);
        int sum = 0;
        for (int k = 0; k < 4; k++) sum += codes[ch][k];
        return ((sum >> 2) * 1000) >> 12;
    endfunction

    task automatic push_frame();
        int e;
        for (int c = 0; c < 13; c++) begin
            e = withhold[c] ? prev_mv[c] : model_mv(c);
            prev_mv[c] = e;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_bank(input string tag);
        int v;
        for (int c = 0; c < 13; c++) begin
            read_mv(c, v);
            check($sformatf("%s_ch%0d", tag, c), v, exp_q.pop_front());
        end
    endtask

    task automatic set_all(input int code);
        for (int c = 0; c < 16; c++) begin
            withhold[c] = 1'b0;
            for (int k = 0; k < 4; k++) codes[c][k] = code;
        end
    endtask

    initial begin
        int s;
        int v;
        int d1;
        int got;
        int lows;
        int act;

        rst     = 1'b1;
        start   = 1'b0;
        start_c = 1'b0;
        rd_ch   = '0;
        rd_ch_c = '0;
        set_all(12'h800);
        for (int c = 0; c < 16; c++) prev_mv[c] = 0;

        repeat (3) step();
        check("rst_den", drp_den, 0);
        check("rst_daddr", drp_daddr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_rd_mv", rd_mv, 0);
        rst = 1'b0;
        read_mv(3, v);
        check("rst_bank3", v, 0);

        // Frame 1: every channel 0x800, stray start while busy.
        set_all(12'h800);
        push_frame();
        pulse_start(s);
        check("f1_req_den", drp_den, 1);
        check("f1_req_addr", drp_daddr, 7'h10);
        check("f1_busy", busy, 1);
        step();
        check("f1_den_pulse", drp_den, 0);
        repeat (7) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(s + 300, "f1_done_cycle");
        check("f1_err", err, 0);
        step();
        check("f1_busy_fall", busy, 0);
        step();
        check("f1_no_restart", drp_den, 0);
        check_bank("f1_bank");
        read_mv(14, v);
        check("rd_ch_oob", v, 0);

        // Frame 2: averaging on ch3, full-scale on ch12, ch5 distinct.
        codes[3][0] = 100; codes[3][1] = 200; codes[3][2] = 300; codes[3][3] = 400;
        for (int k = 0; k < 4; k++) codes[12][k] = 12'hFFF;
        for (int k = 0; k < 4; k++) codes[5][k] = 12'h400;
        push_frame();
        pulse_start(s);
        wait_done(s + 300, "f2_done_cycle");
        check_bank("f2_bank");

        // Frame 3: ch5 never answers.
        set_all(12'h800);
        withhold[5] = 1'b1;
        push_frame();
        pulse_start(s);
        wait_done(s + 300 + (1 + 64 + 1) - 23, "f3_done_cycle");
        check("f3_err", err, 13'h0020);
        check_bank("f3_bank");

        // Reset in the middle of a frame.
        set_all(12'h800);
        rd_ch = 4'd0;
        pulse_start(s);
        while (cyc < s + 50) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_den", drp_den, 0);
        check("mrst_busy", busy, 0);
        check("mrst_rd_mv", rd_mv, 0);
        force_drdy = 1'b1;
        step();
        step();
        force_drdy = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (drp_den !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) act++;
        end
        check("mrst_quiet", act, 0);
        read_mv(0, v);
        check("mrst_bank0", v, 0);
        read_mv(12, v);
        check("mrst_bank12", v, 0);
        for (int c = 0; c < 16; c++) prev_mv[c] = 0;
        push_frame();
        pulse_start(s);
        wait_done(s + 300, "mrst_clean_done");
        check("mrst_clean_err", err, 0);
        check_bank("mrst_bank");

        // Continuous mode instance.
        @(negedge clk);
        start_c = 1'b1;
        s = cyc;
        @(negedge clk);
        start_c = 1'b0;
        d1 = -1;
        for (int i = 0; i < 100; i++) begin
            if (frame_done_c === 1'b1) begin
                d1 = cyc;
                break;
            end
            step();
        end
        check("cont_done1", d1, s + 11);
        step();
        check("cont_req_den", drp_den_c, 1);
        check("cont_req_addr", drp_daddr_c, 7'h10);
        check("cont_busy", busy_c, 1);
        got = -1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy_c !== 1'b1) lows++;
            if (frame_done_c === 1'b1) begin
                got = cyc;
                break;
            end
        end
        check("cont_done2", got, d1 + 11);
        check("cont_busy_held", lows, 0);
        @(negedge clk);
        rd_ch_c = 1'b1;
        @(negedge clk);
        check("cont_mv_ch1", rd_mv_c, 500);
        check("cont_err", err_c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
